merlin_alu_arbiter: RTL and testbench
=====================================

// Module: merlin_alu_arbiter
// PURPOSE
//  Shares one merlin_alu between two requesters (0: issue pipeline, 1: aux/debug unit).
//  Arbitrates per cycle and drives the ALU operands, opcodes and clk_en_i.
//  Returns each registered ALU result to the requester that owns it, over a valid/ready handshake.
//  Stalls the ALU output register while the owner is not ready.
// PARAMETERS
//  XLEN     32  operand/result width
//  ALUOP_W  4   width of ALU opcode (matches RV_ALUOP_RANGE)
// PORTS
//  clk_i            in   1         clock
//  resetb_i         in   1         asynchronous active-low reset
//  clk_en_i         in   1         global clock enable; low freezes all state
//  flush_i          in   1         discard pending result; block further issue this cycle
//  req_valid_i      in   2         per-requester request valid
//  req_ready_o      out  2         per-requester grant; transfer when valid&ready
//  req_op_left_i    in   2*XLEN    op operands, requester n at [n*XLEN +: XLEN]
//  req_op_right_i   in   2*XLEN    op operands, requester n at [n*XLEN +: XLEN]
//  req_cmp_left_i   in   2*XLEN    cmp operands
//  req_cmp_right_i  in   2*XLEN    cmp operands
//  req_opcode_i     in   2*ALUOP_W ALU opcodes
//  req_cmp_opcode_i in   2*3       compare opcodes
//  rsp_valid_o      out  2         result valid for requester n (one-hot or zero)
//  rsp_ready_i      in   2         requester accepts result
//  rsp_result_o     out  XLEN      shared result bus (= alu_op_result_i)
//  rsp_cmp_o        out  1         shared compare bus (= alu_cmp_result_i)
//  alu_clk_en_o     out  1         ALU clk_en_i
//  alu_op_*_o / alu_cmp_*_o / alu_opcode_o / alu_cmp_opcode_o  out  muxed operands and opcodes
//  alu_op_result_i  in   XLEN      ALU registered result
//  alu_cmp_result_i in   1         ALU registered compare
// BEHAVIOUR
//  - State: EMPTY, or FULL(owner 0/1). Reset -> EMPTY, last-grant pointer = 1.
//    Reset values: rsp_valid_o=0, req_ready_o=0, alu_clk_en_o=0.
//  - can_issue = clk_en_i & ~flush_i & (EMPTY | rsp_ready_i[owner]).
//  - Grant is combinational: req_ready_o[n] = can_issue & selected(n).
//    Select only among valid requesters. ALU operand muxes follow the selected requester.
//  - alu_clk_en_o = issue (some valid&ready). Result appears one cycle after issue.
//  - Next state on clk_en_i:
//    - issue -> FULL(granted);
//    - else if FULL & rsp_ready_i[owner] -> EMPTY;
//    - else hold.
//  - rsp_valid_o[owner] = FULL. While FULL and not ready, alu_clk_en_o=0, so the result holds stable.
//  - Back-to-back: result handoff and new issue occur in the same cycle. Throughput is 1 op/cycle.
//  - flush_i: FULL -> EMPTY next cycle. No issue and no rsp handshake counted that cycle.
//    rsp_valid_o still shows for that cycle; the requester ignores it.
//  - Arbitration (macro on): both valid -> grant != last-grant. Pointer updates on issue only.
//  - clk_en_i low: no state change, alu_clk_en_o=0, req_ready_o=0.
//  - Async reset mid-op: result dropped, requesters re-issue. ALU output register is not reset and is don't-care.
// CONFIGURATION
//  MERLIN_ALU_ARB_RR_EN defined: round-robin between requesters as above.
//  Undefined: fixed priority, requester 0 always wins; pointer logic removed.
//  Requester 1 can starve.
// STRUCTURE
//  - riscv_defs.v supplies RV_XLEN, RV_ALUOP_RANGE, RV_ALUOP_*, RV_ALUCOND_*.
//  - Add state encodings MERLIN_ALUARB_EMPTY/FULL there.
//  - One sub-module: merlin_arb2 (2-way arbiter, RR/fixed via macro, pointer register).
// TESTING
//  - Reset: resetb_i=0 -> rsp_valid_o=00, req_ready_o=00, alu_clk_en_o=0. Release, idle: stay 0.
//  - Single: req0 ADD 5+7, rsp_ready=1 -> ready0 same cycle.
//    Next cycle rsp_valid=01, result=12.
//  - Backpressure: req1 SUB 10-3, rsp_ready1=0 for 3 cycles.
//    rsp_valid=10 and result 7 held stable, alu_clk_en_o=0, req0 blocked.
//  - Contention (RR): both valid for 4 cycles -> grants 0,1,0,1; results routed to the matching rsp_valid bit.
//    Fixed priority: 0,0,0,0.
//  - Flush: FULL(0) with rsp_ready0=0, pulse flush_i -> EMPTY next cycle, rsp_valid=00.
//    No grant during the flush cycle.
//  - Compare: req0 cmp LT left=-1, right=1 -> rsp_cmp_o=1. GEU same operands -> 1.
//    clk_en_i low mid-op: everything frozen.

Source files
------------

// File: rtl/merlin_alu_arbiter_pkg.sv
// Shared types for merlin_alu_arbiter: result-slot state encoding and debug view.
// Round-robin arbitration is enabled by defining MERLIN_ALU_ARB_RR_EN.
package merlin_alu_arbiter_pkg;

    typedef enum logic {
        MERLIN_ALUARB_EMPTY = 1'b0,
        MERLIN_ALUARB_FULL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e state;
        logic       owner;
    } arb_dbg_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/merlin_arb2.sv
// Two-way request selector for the ALU arbiter.
// MERLIN_ALU_ARB_RR_EN defined: round-robin with a last-grant pointer; otherwise fixed priority to requester 0.
module merlin_arb2 (
    input  logic       clk_i,
    input  logic       resetb_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

`ifdef MERLIN_ALU_ARB_RR_EN
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        // On contention, the requester that did not win last time goes next.
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (advance_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk_i, resetb_i, advance_i};
    assign gnt_o     = {req_i[1] & ~req_i[0], req_i[0]};
`endif

endmodule

// File: rtl/merlin_alu_arbiter.sv
// Shares one registered merlin_alu between the issue pipeline (0) and the aux/debug unit (1).
// Arbitration mode is selected by MERLIN_ALU_ARB_RR_EN (round-robin) vs fixed priority.
module merlin_alu_arbiter
    import merlin_alu_arbiter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    input  logic                 clk_en_i,
    input  logic                 flush_i,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [2*XLEN-1:0]    req_op_left_i,
    input  logic [2*XLEN-1:0]    req_op_right_i,
    input  logic [2*XLEN-1:0]    req_cmp_left_i,
    input  logic [2*XLEN-1:0]    req_cmp_right_i,
    input  logic [2*ALUOP_W-1:0] req_opcode_i,
    input  logic [5:0]           req_cmp_opcode_i,
    output logic [1:0]           rsp_valid_o,
    input  logic [1:0]           rsp_ready_i,
    output logic [XLEN-1:0]      rsp_result_o,
    output logic                 rsp_cmp_o,
    output logic                 alu_clk_en_o,
    output logic [XLEN-1:0]      alu_op_left_o,
    output logic [XLEN-1:0]      alu_op_right_o,
    output logic [XLEN-1:0]      alu_cmp_left_o,
    output logic [XLEN-1:0]      alu_cmp_right_o,
    output logic [ALUOP_W-1:0]   alu_opcode_o,
    output logic [2:0]           alu_cmp_opcode_o,
    input  logic [XLEN-1:0]      alu_op_result_i,
    input  logic                 alu_cmp_result_i,
    output arb_dbg_t             dbg_state_o
);

    // Handshake: a request transfers when req_valid_i[n] & req_ready_o[n];
    // a result transfers when rsp_valid_o[n] & rsp_ready_i[n] with clk_en_i high and flush_i low.
    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] sel;
    logic       sel_idx;
    logic       can_issue;
    logic       issue;

    merlin_arb2 u_arb (
        .clk_i     (clk_i),
        .resetb_i  (resetb_i),
        .req_i     (req_valid_i),
        .advance_i (issue),
        .gnt_o     (sel)
    );

    assign sel_idx          = sel[1];
    assign alu_op_left_o    = sel_idx ? req_op_left_i[XLEN +: XLEN]   : req_op_left_i[0 +: XLEN];
    assign alu_op_right_o   = sel_idx ? req_op_right_i[XLEN +: XLEN]  : req_op_right_i[0 +: XLEN];
    assign alu_cmp_left_o   = sel_idx ? req_cmp_left_i[XLEN +: XLEN]  : req_cmp_left_i[0 +: XLEN];
    assign alu_cmp_right_o  = sel_idx ? req_cmp_right_i[XLEN +: XLEN] : req_cmp_right_i[0 +: XLEN];
    assign alu_opcode_o     = sel_idx ? req_opcode_i[ALUOP_W +: ALUOP_W] : req_opcode_i[0 +: ALUOP_W];
    assign alu_cmp_opcode_o = sel_idx ? req_cmp_opcode_i[5:3] : req_cmp_opcode_i[2:0];
    assign rsp_result_o     = alu_op_result_i;
    assign rsp_cmp_o        = alu_cmp_result_i;
    assign dbg_state_o      = '{state: state_q, owner: owner_q};

    always_comb begin
        // Grants are masked while reset is asserted so nothing issues before the slot is known empty.
        can_issue = resetb_i & clk_en_i & ~flush_i &
                    ((state_q == MERLIN_ALUARB_EMPTY) | rsp_ready_i[owner_q]);
        req_ready_o  = can_issue ? sel : 2'b00;
        issue        = |(req_valid_i & req_ready_o);
        alu_clk_en_o = issue;
        rsp_valid_o  = (state_q == MERLIN_ALUARB_FULL) ? onehot2(owner_q) : 2'b00;

        state_d = state_q;
        owner_d = owner_q;
        if (clk_en_i) begin
            if (issue) begin
                state_d = MERLIN_ALUARB_FULL;
                owner_d = sel_idx;
            end else if ((state_q == MERLIN_ALUARB_FULL) && (flush_i || rsp_ready_i[owner_q])) begin
                state_d = MERLIN_ALUARB_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= MERLIN_ALUARB_EMPTY;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_merlin_alu_arbiter.sv
// Self-checking bench for merlin_alu_arbiter with a behavioural ALU and reference model.
// Honours MERLIN_ALU_ARB_RR_EN the same way as the design.
module tb_merlin_alu_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 4;
    localparam int W    = XLEN + 2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [2:0] C_LT   = 3'd4;
    localparam logic [2:0] C_GEU  = 3'd7;

    logic              clk = 1'b0;
    logic              resetb;
    logic              clk_en;
    logic              flush;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*XLEN-1:0] op_l, op_r, cmp_l, cmp_r;
    logic [2*AW-1:0]   opcode;
    logic [5:0]        cmp_op;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [XLEN-1:0]   rsp_result;
    logic              rsp_cmp;
    logic              alu_clk_en;
    logic [XLEN-1:0]   alu_l, alu_r, alu_cl, alu_cr;
    logic [AW-1:0]     alu_opc;
    logic [2:0]        alu_copc;
    logic [XLEN-1:0]   alu_res_q;
    logic              alu_cmp_q;
    logic [1:0]        dbg_state;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    int m_full  = 0;
    int m_owner = 0;
    int m_last  = 1;

    merlin_alu_arbiter #(.XLEN(XLEN), .ALUOP_W(AW)) dut (
        .clk_i            (clk),
        .resetb_i         (resetb),
        .clk_en_i         (clk_en),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_left_i    (op_l),
        .req_op_right_i   (op_r),
        .req_cmp_left_i   (cmp_l),
        .req_cmp_right_i  (cmp_r),
        .req_opcode_i     (opcode),
        .req_cmp_opcode_i (cmp_op),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_result_o     (rsp_result),
        .rsp_cmp_o        (rsp_cmp),
        .alu_clk_en_o     (alu_clk_en),
        .alu_op_left_o    (alu_l),
        .alu_op_right_o   (alu_r),
        .alu_cmp_left_o   (alu_cl),
        .alu_cmp_right_o  (alu_cr),
        .alu_opcode_o     (alu_opc),
        .alu_cmp_opcode_o (alu_copc),
        .alu_op_result_i  (alu_res_q),
        .alu_cmp_result_i (alu_cmp_q),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- arithmetic helpers ----------------
    function automatic logic [XLEN-1:0] calc_op(input logic [3:0] op, input logic [XLEN-1:0] a, b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic calc_cmp(input logic [2:0] op, input logic [XLEN-1:0] a, b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural stand-in for the registered merlin_alu.
    always @(posedge clk) begin
        if (alu_clk_en) begin
            alu_res_q <= calc_op(alu_opc, alu_l, alu_r);
            alu_cmp_q <= calc_cmp(alu_copc, alu_cl, alu_cr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: grants, slot occupancy, expected results ----------------
    always @(negedge clk) begin
        logic [1:0] g;
        logic       can;
        logic       idx;
        logic [W-1:0] item;
        if (!resetb) begin
            check("reset_req_ready", req_ready, 2'b00);
            check("reset_rsp_valid", rsp_valid, 2'b00);
            check("reset_alu_clk_en", alu_clk_en, 1'b0);
            m_full  = 0;
            m_owner = 0;
            m_last  = 1;
            exp_q.delete();
        end else begin
            can = clk_en && !flush && (m_full == 0 || rsp_ready[m_owner]);
            case (req_valid)
                2'b01:   g = 2'b01;
                2'b10:   g = 2'b10;
`ifdef MERLIN_ALU_ARB_RR_EN
                2'b11:   g = (m_last == 1) ? 2'b01 : 2'b10;
`else
                2'b11:   g = 2'b01;
`endif
                default: g = 2'b00;
            endcase
            if (!can) g = 2'b00;
            idx  = g[1];
            item = {idx,
                    calc_cmp(cmp_op[idx*3 +: 3], cmp_l[idx*XLEN +: XLEN], cmp_r[idx*XLEN +: XLEN]),
                    calc_op(opcode[idx*AW +: AW], op_l[idx*XLEN +: XLEN], op_r[idx*XLEN +: XLEN])};
            check("req_ready", req_ready, g);
            check("alu_clk_en", alu_clk_en, g != 2'b00);
            check("rsp_valid", rsp_valid, (m_full != 0) ? (2'b01 << m_owner) : 2'b00);
            check("dbg_full", dbg_state[1], m_full != 0);
            #2;
            if (clk_en) begin
                if (g != 2'b00) begin
                    exp_q.push_back(item);
                    m_full  = 1;
                    m_owner = idx;
                    m_last  = idx;
                end else if (m_full != 0 && (flush || rsp_ready[m_owner])) begin
                    if (flush && exp_q.size() > 0) void'(exp_q.pop_front());
                    m_full = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] it;
        if (resetb && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", rsp_valid, 2'b00);
            end else begin
                it = exp_q[0];
                check("rsp_owner", rsp_valid, it[W-1] ? 2'b10 : 2'b01);
                check("rsp_result", rsp_result, it[XLEN-1:0]);
                check("rsp_cmp", rsp_cmp, it[XLEN]);
                if (clk_en && !flush && (rsp_valid & rsp_ready) != 2'b00) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int n, input logic [XLEN-1:0] l, r, input logic [3:0] op,
                           input logic [XLEN-1:0] cl, cr, input logic [2:0] cop);
        op_l[n*XLEN +: XLEN]  = l;
        op_r[n*XLEN +: XLEN]  = r;
        cmp_l[n*XLEN +: XLEN] = cl;
        cmp_r[n*XLEN +: XLEN] = cr;
        opcode[n*AW +: AW]    = op;
        cmp_op[n*3 +: 3]      = cop;
    endtask

    task automatic rand_req(input int n);
        set_req(n, $urandom, $urandom, 4'($urandom_range(0, 5)), $urandom, $urandom,
                3'($urandom_range(0, 7)));
    endtask

    task automatic cycle(input logic [1:0] v, input logic [1:0] rr, input logic fl, input logic ce);
        req_valid = v;
        rsp_ready = rr;
        flush     = fl;
        clk_en    = ce;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetb = 1'b0;
        op_l = '0; op_r = '0; cmp_l = '0; cmp_r = '0; opcode = '0; cmp_op = '0;
        repeat (3) cycle(2'b00, 2'b00, 1'b0, 1'b1);
        resetb = 1'b1;
        repeat (2) cycle(2'b00, 2'b00, 1'b0, 1'b1);

        // single ADD on requester 0
        set_req(0, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, 3'd0);
        cycle(2'b01, 2'b11, 1'b0, 1'b1);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // backpressure on requester 1 with requester 0 waiting
        set_req(1, 32'd10, 32'd3, OP_SUB, 32'd0, 32'd0, 3'd0);
        cycle(2'b10, 2'b11, 1'b0, 1'b1);
        repeat (3) cycle(2'b11, 2'b01, 1'b0, 1'b1);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // contention
        rand_req(0);
        rand_req(1);
        repeat (4) cycle(2'b11, 2'b11, 1'b0, 1'b1);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // flush while full and unaccepted
        cycle(2'b01, 2'b00, 1'b0, 1'b1);
        cycle(2'b01, 2'b00, 1'b1, 1'b1);
        cycle(2'b00, 2'b00, 1'b0, 1'b1);

        // compares
        set_req(0, 32'd0, 32'd0, OP_ADD, 32'hFFFF_FFFF, 32'd1, C_LT);
        cycle(2'b01, 2'b11, 1'b0, 1'b1);
        set_req(0, 32'd0, 32'd0, OP_ADD, 32'hFFFF_FFFF, 32'd1, C_GEU);
        cycle(2'b01, 2'b11, 1'b0, 1'b1);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // clock enable low mid-op
        cycle(2'b01, 2'b00, 1'b0, 1'b1);
        repeat (2) cycle(2'b11, 2'b11, 1'b0, 1'b0);
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // reset mid-op
        cycle(2'b10, 2'b00, 1'b0, 1'b1);
        resetb = 1'b0;
        cycle(2'b11, 2'b11, 1'b0, 1'b1);
        resetb = 1'b1;
        cycle(2'b00, 2'b11, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_req(0);
            rand_req(1);
            resetb = ($urandom_range(0, 199) != 0);
            cycle(2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) != 0));
        end
        resetb = 1'b1;

        repeat (4) cycle(2'b00, 2'b11, 1'b0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
